scsi_fifo_sm: RTL and testbench

SCSI-side DMA byte-transfer state machine that sits directly upstream/downstream of the SDMAC FIFO. It runs the DREQ_/DACK_ handshake and read/write strobes to the SCSI controller. It also generates the single-cycle FIFO control pulses (LBYTE_, INCBO, INCFIFO/INCNI, DECFIFO/INCNO) that move bytes into or out of the FIFO. It handles partial-longword flush at the end of a SCSI-to-memory transfer.

---
 rtl/scsi_fifo_sm.sv | 180 ++++++++++++++++++
 tb/tb_scsi_fifo_sm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsi_fifo_sm.sv
// SCSI-side DMA byte mover: runs DREQ_/DACK_ and SIOR_/SIOW_ to the SCSI controller and
// issues the one-clock FIFO control pulses, including partial-longword flush.
module scsi_fifo_sm #(
    parameter int unsigned STROBE_CYCLES  = 2,
    parameter int unsigned RECOVER_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_dmaena,
    input  logic i_dmadir,
    input  logic i_dreq_n,
    input  logic i_flush,
    input  logic i_fifofull,
    input  logic i_fifoempty,
    input  logic i_boeq0,
    input  logic i_boeq3,
    output logic o_dack_n,
    output logic o_sior_n,
    output logic o_siow_n,
    output logic o_lbyte_n,
    output logic o_incbo,
    output logic o_incfifo,
    output logic o_incni,
    output logic o_decfifo,
    output logic o_incno,
    output logic o_flushdone,
    output logic o_busy
);

    typedef enum logic [2:0] {
        StIdle, StSetup, StStrobe, StLatch, StUpdate, StRecover, StFlush
    } state_t;

    localparam logic [3:0] StrobeLoad  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] RecoverLoad = 4'(RECOVER_CYCLES - 1);

    state_t     r_state, w_state_d;
    logic [3:0] r_cnt, w_cnt_d;
    logic       r_dir, w_dir_d;
    logic       r_flush_pend, w_flush_pend_d;

    logic r_dack_n, r_sior_n, r_siow_n, r_lbyte_n;
    logic r_incbo, r_incfifo, r_incni, r_decfifo, r_incno, r_flushdone, r_busy;
    logic w_dack_n_d, w_sior_n_d, w_siow_n_d, w_lbyte_n_d;
    logic w_incbo_d, w_incfifo_d, w_incni_d, w_decfifo_d, w_incno_d, w_flushdone_d;
    logic w_decide, w_ready;

    assign w_ready = i_dmadir ? !i_fifofull : !i_fifoempty;

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_dir_d        = r_dir;
        w_flush_pend_d = r_flush_pend | i_flush;
        w_dack_n_d     = r_dack_n;
        w_sior_n_d     = r_sior_n;
        w_siow_n_d     = r_siow_n;
        w_lbyte_n_d    = 1'b1;
        w_incbo_d      = 1'b0;
        w_incfifo_d    = 1'b0;
        w_incni_d      = 1'b0;
        w_decfifo_d    = 1'b0;
        w_incno_d      = 1'b0;
        w_flushdone_d  = 1'b0;
        w_decide       = 1'b0;

        unique case (r_state)
            StIdle: w_decide = 1'b1;
            StSetup: begin
                w_state_d = StStrobe;
                w_cnt_d   = StrobeLoad;
                if (r_dir) w_sior_n_d = 1'b0;
                else       w_siow_n_d = 1'b0;
            end
            StStrobe: begin
                if (r_cnt == 4'd0) begin
                    w_state_d   = StLatch;
                    w_sior_n_d  = 1'b1;
                    w_siow_n_d  = 1'b1;
                    w_lbyte_n_d = !r_dir;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            StLatch: begin
                w_state_d = StUpdate;
                w_incbo_d = 1'b1;
                if (i_boeq3) begin
                    w_incfifo_d = r_dir;
                    w_incni_d   = r_dir;
                    w_decfifo_d = !r_dir;
                    w_incno_d   = !r_dir;
                end
            end
            StUpdate: begin
                w_state_d  = StRecover;
                w_dack_n_d = 1'b1;
                w_cnt_d    = RecoverLoad;
            end
            StRecover: begin
                // The last recovery clock doubles as the idle decision, giving a 6-clock byte
                if (r_cnt == 4'd0) w_decide = 1'b1;
                else               w_cnt_d  = r_cnt - 4'd1;
            end
            StFlush: begin
                w_state_d      = StIdle;
                w_flushdone_d  = 1'b1;
                w_incfifo_d    = !i_boeq0;
                w_incni_d      = !i_boeq0;
                w_flush_pend_d = i_flush;
            end
            default: w_state_d = StIdle;
        endcase

        if (w_decide) begin
            w_state_d = StIdle;
            if (r_flush_pend || i_flush) begin
                if (i_dmadir) begin
                    w_state_d = StFlush;
                end else begin
                    w_flushdone_d  = 1'b1;
                    w_flush_pend_d = 1'b0;
                end
            end else if (i_dmaena && !i_dreq_n && w_ready) begin
                w_state_d  = StSetup;
                w_dack_n_d = 1'b0;
                w_dir_d    = i_dmadir;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_dir        <= 1'b0;
            r_flush_pend <= 1'b0;
            r_dack_n     <= 1'b1;
            r_sior_n     <= 1'b1;
            r_siow_n     <= 1'b1;
            r_lbyte_n    <= 1'b1;
            r_incbo      <= 1'b0;
            r_incfifo    <= 1'b0;
            r_incni      <= 1'b0;
            r_decfifo    <= 1'b0;
            r_incno      <= 1'b0;
            r_flushdone  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_dir        <= w_dir_d;
            r_flush_pend <= w_flush_pend_d;
            r_dack_n     <= w_dack_n_d;
            r_sior_n     <= w_sior_n_d;
            r_siow_n     <= w_siow_n_d;
            r_lbyte_n    <= w_lbyte_n_d;
            r_incbo      <= w_incbo_d;
            r_incfifo    <= w_incfifo_d;
            r_incni      <= w_incni_d;
            r_decfifo    <= w_decfifo_d;
            r_incno      <= w_incno_d;
            r_flushdone  <= w_flushdone_d;
            r_busy       <= (w_state_d != StIdle);
        end
    end

    assign o_dack_n    = r_dack_n;
    assign o_sior_n    = r_sior_n;
    assign o_siow_n    = r_siow_n;
    assign o_lbyte_n   = r_lbyte_n;
    assign o_incbo     = r_incbo;
    assign o_incfifo   = r_incfifo;
    assign o_incni     = r_incni;
    assign o_decfifo   = r_decfifo;
    assign o_incno     = r_incno;
    assign o_flushdone = r_flushdone;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_scsi_fifo_sm.sv
// Bench for scsi_fifo_sm: a behavioural FIFO (byte pointer + longword count) answers the DUT,
// and per-scenario tasks compare pulse counts and timing against arithmetic expectations.
module tb_scsi_fifo_sm;
    localparam int STROBE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1, dmaena = 1'b1, dmadir = 1'b1, dreq_n = 1'b0, flush = 1'b0;
    logic fifofull, fifoempty, boeq0, boeq3;
    logic o_dack_n, o_sior_n, o_siow_n, o_lbyte_n, o_incbo, o_incfifo, o_incni;
    logic o_decfifo, o_incno, o_flushdone, o_busy;
    logic [6:0] pv, prev_pv = 7'd0;

    int bo = 0, cnt = 0;
    int preset_bo = 0, preset_cnt = 0, gen = 0, seen_gen = -1, drain_gen = 0, seen_drain = 0;
    int cyc = 0, last_incbo = -1, min_gap = 1000, max_gap = 0;
    int n_incbo = 0, n_incfifo = 0, n_incni = 0, n_decfifo = 0, n_incno = 0, n_lbyte = 0;
    int n_flushdone = 0, n_flush_inc = 0, n_fifo_bo = 0, n_dack = 0;
    int n_sior_clk = 0, n_siow_clk = 0, sior_run = 0, siow_run = 0;
    int bad_r = 0, bad_w = 0, pair_bad = 0, pulse_bad = 0;
    logic prev_dack = 1'b1;
    int n_checks = 0, n_pass = 0;

    scsi_fifo_sm #(.STROBE_CYCLES(2), .RECOVER_CYCLES(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_dmaena(dmaena), .i_dmadir(dmadir), .i_dreq_n(dreq_n),
        .i_flush(flush), .i_fifofull(fifofull), .i_fifoempty(fifoempty), .i_boeq0(boeq0),
        .i_boeq3(boeq3), .o_dack_n(o_dack_n), .o_sior_n(o_sior_n), .o_siow_n(o_siow_n),
        .o_lbyte_n(o_lbyte_n), .o_incbo(o_incbo), .o_incfifo(o_incfifo), .o_incni(o_incni),
        .o_decfifo(o_decfifo), .o_incno(o_incno), .o_flushdone(o_flushdone), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    assign boeq0     = (bo == 0);
    assign boeq3     = (bo == 3);
    assign fifofull  = (cnt >= 8);
    assign fifoempty = (cnt == 0);
    assign pv = {o_incbo, o_incfifo, o_incni, o_decfifo, o_incno, o_flushdone, !o_lbyte_n};

    // FIFO model and event counters, updated on the falling edge while outputs are stable
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (gen != seen_gen) begin
            seen_gen <= gen;
            bo <= preset_bo; cnt <= preset_cnt;
            n_incbo <= 0; n_incfifo <= 0; n_incni <= 0; n_decfifo <= 0; n_incno <= 0;
            n_lbyte <= 0; n_flushdone <= 0; n_flush_inc <= 0; n_fifo_bo <= 0; n_dack <= 0;
            n_sior_clk <= 0; n_siow_clk <= 0; bad_r <= 0; bad_w <= 0; pair_bad <= 0;
            pulse_bad <= 0; last_incbo <= -1; min_gap <= 1000; max_gap <= 0;
        end else if (rst) begin
            sior_run <= 0; siow_run <= 0; prev_dack <= 1'b1; prev_pv <= 7'd0;
        end else begin
            if (drain_gen != seen_drain) begin
                seen_drain <= drain_gen;
                cnt <= cnt - 1;
            end else begin
                cnt <= cnt + (o_incfifo ? 1 : 0) - (o_decfifo ? 1 : 0);
            end
            if (o_incbo) bo <= (bo + 1) % 4;
            else if (o_incfifo) bo <= 0;
            if (o_incbo) begin
                n_incbo <= n_incbo + 1;
                last_incbo <= cyc;
                if (last_incbo >= 0) begin
                    if (cyc - last_incbo < min_gap) min_gap <= cyc - last_incbo;
                    if (cyc - last_incbo > max_gap) max_gap <= cyc - last_incbo;
                end
            end
            if (o_incfifo) n_incfifo <= n_incfifo + 1;
            if (o_incni) n_incni <= n_incni + 1;
            if (o_decfifo) n_decfifo <= n_decfifo + 1;
            if (o_incno) n_incno <= n_incno + 1;
            if (!o_lbyte_n) n_lbyte <= n_lbyte + 1;
            if (o_flushdone) n_flushdone <= n_flushdone + 1;
            if (o_flushdone && o_incfifo) n_flush_inc <= n_flush_inc + 1;
            if (o_incfifo && o_incbo) n_fifo_bo <= n_fifo_bo + 1;
            if (o_incfifo != o_incni || o_decfifo != o_incno) pair_bad <= pair_bad + 1;
            if ((pv & prev_pv) != 7'd0) pulse_bad <= pulse_bad + 1;
            prev_pv <= pv;
            if (!o_dack_n && prev_dack) n_dack <= n_dack + 1;
            prev_dack <= o_dack_n;
            if (!o_sior_n) begin
                sior_run <= sior_run + 1; n_sior_clk <= n_sior_clk + 1;
            end else begin
                if (sior_run != 0 && sior_run != STROBE) bad_r <= bad_r + 1;
                sior_run <= 0;
            end
            if (!o_siow_n) begin
                siow_run <= siow_run + 1; n_siow_clk <= n_siow_clk + 1;
            end else begin
                if (siow_run != 0 && siow_run != STROBE) bad_w <= bad_w + 1;
                siow_run <= 0;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic prep(input int b, input int c);
        preset_bo = b; preset_cnt = c; gen = gen + 1;
        tick;
    endtask

    task automatic wait_idle;
        int to;
        to = 0;
        while (o_busy && to < 100) begin tick; to++; end
        repeat (3) tick;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL wait_idle busy=%b want 0", o_busy); else n_pass++;
    endtask

    task automatic wait_sior_low;
        int to;
        to = 0;
        while (o_sior_n && to < 30) begin tick; to++; end
        n_checks++; if (o_sior_n !== 1'b0) $display("FAIL sior_start got %b want 0", o_sior_n); else n_pass++;
    endtask

    task automatic run_bytes(input int n);
        int to;
        to = 0;
        dreq_n = 1'b0;
        while (n_dack < n && to < 20 * n + 20) begin tick; to++; end
        dreq_n = 1'b1;
        n_checks++; if (n_dack !== n) $display("FAIL run_bytes_dack got %0d want %0d", n_dack, n); else n_pass++;
        wait_idle;
    endtask

    task automatic test_reset;
        repeat (3) tick;
        n_checks++;
        if ({o_dack_n, o_sior_n, o_siow_n, o_lbyte_n, o_incbo, o_incfifo, o_incni, o_decfifo,
             o_incno, o_flushdone, o_busy} !== 11'b1111_0000000)
            $display("FAIL reset_outputs got %b want 11110000000", {o_dack_n, o_sior_n, o_siow_n,
                     o_lbyte_n, o_incbo, o_incfifo, o_incni, o_decfifo, o_incno, o_flushdone, o_busy});
        else n_pass++;
        prep(0, 0);
        rst = 1'b0;
        tick;
        n_checks++; if (o_dack_n !== 1'b0) $display("FAIL dack_first got %b want 0", o_dack_n); else n_pass++;
        dreq_n = 1'b1;
        repeat (4) tick;
        n_checks++; if (o_dack_n !== 1'b0) $display("FAIL dack_hold got %b want 0", o_dack_n); else n_pass++;
        tick;
        n_checks++; if (o_dack_n !== 1'b1) $display("FAIL byte_latency dack got %b want 1", o_dack_n); else n_pass++;
        wait_idle;
    endtask

    task automatic test_write_burst;
        prep(0, 0);
        dmadir = 1'b1;
        run_bytes(4);
        n_checks++; if (n_incbo !== 4) $display("FAIL wr_incbo got %0d want 4", n_incbo); else n_pass++;
        n_checks++; if (min_gap !== 6 || max_gap !== 6) $display("FAIL wr_period got %0d..%0d want 6", min_gap, max_gap); else n_pass++;
        n_checks++; if (n_lbyte !== 4) $display("FAIL wr_lbyte got %0d want 4", n_lbyte); else n_pass++;
        n_checks++; if (n_incfifo !== 1 || n_incni !== 1) $display("FAIL wr_incfifo got %0d/%0d want 1/1", n_incfifo, n_incni); else n_pass++;
        n_checks++; if (n_fifo_bo !== 1) $display("FAIL wr_incfifo_with_4th got %0d want 1", n_fifo_bo); else n_pass++;
        n_checks++; if (n_sior_clk !== 4 * STROBE || n_siow_clk !== 0) $display("FAIL wr_strobes got r%0d w%0d want r%0d w0", n_sior_clk, n_siow_clk, 4 * STROBE); else n_pass++;
        n_checks++; if (bad_r !== 0 || pulse_bad !== 0) $display("FAIL wr_shape got strobe%0d pulse%0d want 0 0", bad_r, pulse_bad); else n_pass++;
    endtask

    task automatic test_fifo_full;
        int to;
        prep(0, 0);
        dmadir = 1'b1;
        dreq_n = 1'b0;
        to = 0;
        while (n_incfifo < 8 && to < 400) begin tick; to++; end
        repeat (30) tick;
        n_checks++; if (n_incfifo !== 8) $display("FAIL full_incfifo got %0d want 8", n_incfifo); else n_pass++;
        n_checks++; if (n_dack !== 32 || n_incbo !== 32) $display("FAIL full_bytes got %0d/%0d want 32/32", n_dack, n_incbo); else n_pass++;
        n_checks++; if (o_dack_n !== 1'b1 || o_busy !== 1'b0) $display("FAIL full_blocked dack=%b busy=%b want 1 0", o_dack_n, o_busy); else n_pass++;
        drain_gen = drain_gen + 1;
        to = 0;
        while (n_dack < 33 && to < 20) begin tick; to++; end
        dreq_n = 1'b1;
        n_checks++; if (n_dack !== 33) $display("FAIL full_resume got %0d want 33", n_dack); else n_pass++;
        wait_idle;
    endtask

    task automatic test_flush;
        prep(0, 0);
        dmadir = 1'b1;
        run_bytes(2);
        flush = 1'b1; tick; flush = 1'b0;
        repeat (5) tick;
        n_checks++; if (n_flushdone !== 1 || n_flush_inc !== 1 || n_incni !== 1) $display("FAIL flush_partial done=%0d inc=%0d ni=%0d want 1 1 1", n_flushdone, n_flush_inc, n_incni); else n_pass++;
        prep(0, 1);
        flush = 1'b1; tick; flush = 1'b0;
        repeat (5) tick;
        n_checks++; if (n_flushdone !== 1 || n_incfifo !== 0) $display("FAIL flush_bo0 done=%0d inc=%0d want 1 0", n_flushdone, n_incfifo); else n_pass++;
        prep(2, 1);
        dmadir = 1'b0;
        flush = 1'b1; tick; flush = 1'b0;
        repeat (5) tick;
        n_checks++; if (n_flushdone !== 1 || n_incfifo !== 0 || n_decfifo !== 0) $display("FAIL flush_dir0 done=%0d inc=%0d dec=%0d want 1 0 0", n_flushdone, n_incfifo, n_decfifo); else n_pass++;
    endtask

    task automatic test_flush_busy;
        prep(0, 0);
        dmadir = 1'b1;
        dreq_n = 1'b0;
        wait_sior_low;
        flush = 1'b1; dreq_n = 1'b1; tick; flush = 1'b0;
        n_checks++; if (n_flushdone !== 0) $display("FAIL flush_busy_early got %0d want 0", n_flushdone); else n_pass++;
        wait_idle;
        n_checks++; if (n_incbo !== 1 || n_flushdone !== 1 || n_flush_inc !== 1) $display("FAIL flush_busy bo=%0d done=%0d inc=%0d want 1 1 1", n_incbo, n_flushdone, n_flush_inc); else n_pass++;
    endtask

    task automatic test_read;
        prep(0, 1);
        dmadir = 1'b0;
        dreq_n = 1'b0;
        repeat (60) tick;
        dreq_n = 1'b1;
        n_checks++; if (n_incbo !== 4 || n_dack !== 4) $display("FAIL rd_bytes got %0d/%0d want 4/4", n_incbo, n_dack); else n_pass++;
        n_checks++; if (n_siow_clk !== 4 * STROBE || n_sior_clk !== 0 || bad_w !== 0) $display("FAIL rd_strobes w%0d r%0d bad%0d want %0d 0 0", n_siow_clk, n_sior_clk, bad_w, 4 * STROBE); else n_pass++;
        n_checks++; if (n_decfifo !== 1 || n_incno !== 1 || n_incfifo !== 0 || n_lbyte !== 0) $display("FAIL rd_pulses dec=%0d no=%0d inc=%0d lb=%0d want 1 1 0 0", n_decfifo, n_incno, n_incfifo, n_lbyte); else n_pass++;
        n_checks++; if (o_busy !== 1'b0 || o_dack_n !== 1'b1) $display("FAIL rd_empty_idle busy=%b dack=%b want 0 1", o_busy, o_dack_n); else n_pass++;
    endtask

    task automatic test_abort;
        prep(0, 0);
        dmadir = 1'b1;
        dreq_n = 1'b0;
        wait_sior_low;
        rst = 1'b1;
        #1;
        n_checks++; if (o_sior_n !== 1'b1 || o_dack_n !== 1'b1 || o_busy !== 1'b0) $display("FAIL rst_abort sior=%b dack=%b busy=%b want 1 1 0", o_sior_n, o_dack_n, o_busy); else n_pass++;
        dreq_n = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        repeat (10) tick;
        n_checks++; if (n_incbo !== 0 || n_lbyte !== 0) $display("FAIL rst_no_pulse incbo=%0d lbyte=%0d want 0 0", n_incbo, n_lbyte); else n_pass++;
        prep(0, 0);
        dreq_n = 1'b0;
        wait_sior_low;
        dmaena = 1'b0;
        repeat (20) tick;
        n_checks++; if (n_incbo !== 1 || n_lbyte !== 1 || n_dack !== 1) $display("FAIL ena_drop bo=%0d lb=%0d dack=%0d want 1 1 1", n_incbo, n_lbyte, n_dack); else n_pass++;
        n_checks++; if (o_dack_n !== 1'b1 || o_busy !== 1'b0) $display("FAIL ena_drop_idle dack=%b busy=%b want 1 0", o_dack_n, o_busy); else n_pass++;
        dreq_n = 1'b1;
        dmaena = 1'b1;
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            int d, b0, c0, n, lw;
            d  = int'($urandom_range(0, 1));
            b0 = int'($urandom_range(0, 3));
            if (d == 1) begin
                c0 = int'($urandom_range(0, 5));
                n  = int'($urandom_range(1, 12));
            end else begin
                c0 = int'($urandom_range(1, 3));
                n  = int'($urandom_range(1, 4 * c0 - b0));
            end
            lw = (b0 + n) / 4;
            dmadir = (d == 1);
            prep(b0, c0);
            run_bytes(n);
            n_checks++; if (n_incbo !== n) $display("FAIL rnd%0d_incbo got %0d want %0d", it, n_incbo, n); else n_pass++;
            n_checks++; if (n_incfifo !== (d == 1 ? lw : 0) || n_decfifo !== (d == 1 ? 0 : lw)) $display("FAIL rnd%0d_lw inc=%0d dec=%0d want %0d", it, n_incfifo, n_decfifo, lw); else n_pass++;
            n_checks++; if (n_lbyte !== (d == 1 ? n : 0)) $display("FAIL rnd%0d_lbyte got %0d want %0d", it, n_lbyte, d == 1 ? n : 0); else n_pass++;
            n_checks++; if (n_sior_clk + n_siow_clk !== n * STROBE || (d == 1 ? n_siow_clk : n_sior_clk) !== 0) $display("FAIL rnd%0d_strobe r%0d w%0d want total %0d", it, n_sior_clk, n_siow_clk, n * STROBE); else n_pass++;
            n_checks++; if (bo !== (b0 + n) % 4 || cnt !== (d == 1 ? c0 + lw : c0 - lw)) $display("FAIL rnd%0d_fifo bo=%0d cnt=%0d want %0d %0d", it, bo, cnt, (b0 + n) % 4, d == 1 ? c0 + lw : c0 - lw); else n_pass++;
            n_checks++; if (pair_bad !== 0 || pulse_bad !== 0 || bad_r !== 0 || bad_w !== 0) $display("FAIL rnd%0d_shape pair%0d pulse%0d r%0d w%0d want 0", it, pair_bad, pulse_bad, bad_r, bad_w); else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_write_burst;
        test_fifo_full;
        test_flush;
        test_flush_busy;
        test_read;
        test_abort;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
